// File: rtl/axis_word_packer_pkg.sv
// Shared constants and width helpers for the byte-to-word packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_word_packer_pkg;

  // Output-register occupancy: a word is held exactly when out_valid_o is high
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Number of input lanes per output word
  function automatic int ratio_f(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  // Width of a lane index (0..ratio-1)
  function automatic int lane_idx_w_f(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Width of a lane count (1..ratio)
  function automatic int cnt_w_f(input int ratio);
    return $clog2(ratio) + 1;
  endfunction

endpackage

// File: rtl/axis_word_packer_acc.sv
// Lane accumulator: collects input lanes little-endian and exposes the word with the current lane merged.
// Latency: o_merged is combinational; stored lanes appear in r_acc one cycle after acceptance.
// Backpressure: none internally; the caller only asserts i_lane_vld for accepted lanes.
module axis_word_packer_acc #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  parameter int CW    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_cke,
  input  logic                  i_rst,
  input  logic                  i_lane_vld,
  input  logic [IN_W-1:0]       i_lane_dat,
  input  logic                  i_clr,
  output logic [CW-1:0]         o_cnt,
  output logic [RATIO*IN_W-1:0] o_merged
);

  logic [RATIO*IN_W-1:0] r_acc;
  logic [CW-1:0]         r_cnt;

  assign o_cnt = r_cnt;

  // Overlay the incoming lane at the current lane index; unfilled lanes stay zero
  always_comb begin
    o_merged = r_acc;
    for (int k = 0; k < RATIO; k++) begin
      if (i_lane_vld && (r_cnt == CW'(k))) begin
        o_merged[k*IN_W +: IN_W] = i_lane_dat;
      end
    end
  end

  // Clear on word completion (the merged word leaves via the output register), else append
  always_ff @(posedge i_clk) begin
    if (i_cke) begin
      if (i_rst || i_clr) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (i_lane_vld) begin
        r_acc <= o_merged;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/iob_reg_re.sv
// Generic register with clock enable, synchronous reset and load enable.
// Latency: 1 cycle from data_i to data_o when en_i is high.
// Backpressure: none; holds whenever cke_i or en_i is low.
module iob_reg_re #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  // Reset wins over load; everything frozen while the clock enable is low
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        data_o <= RST_VAL;
      end else if (en_i) begin
        data_o <= data_i;
      end
    end
  end

endmodule

// File: rtl/axis_word_packer.sv
// Packs a narrow lane stream little-endian into AXI_DATA_W words with lane count; optional AXIS_WORD_PACKER_FLUSH_EN adds flush_i.
// Latency: 1 cycle from the completing input lane to out_valid_o; one lane per cycle sustained.
// Backpressure: in_ready_o = !out_valid_o || out_ready_i; held word stays stable until consumed.
module axis_word_packer
  import axis_word_packer_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int AXI_DATA_W = 32,
  parameter int CNT_W      = cnt_w_f(ratio_f(AXI_DATA_W, IN_W))
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,
`ifdef AXIS_WORD_PACKER_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic [IN_W-1:0]       in_data_i,
  input  logic                  in_valid_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  output logic [AXI_DATA_W-1:0] out_data_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  output logic [CNT_W-1:0]      out_nbytes_o,
  input  logic                  out_ready_i
);

  localparam int RATIO = ratio_f(AXI_DATA_W, IN_W);
  localparam int CW    = lane_idx_w_f(RATIO);

  logic [CW-1:0]         w_cnt;
  logic [AXI_DATA_W-1:0] w_merged;
  logic [0:0]            w_state;
  logic                  w_free;
  logic                  w_accept;
  logic                  w_consume;
  logic                  w_lane_done;
  logic                  w_flush;
  logic                  w_complete;
  logic [CNT_W-1:0]      w_fill;

  // Occupancy of the single output register doubles as the EMPTY/FULL state
  assign w_state     = out_valid_o ? ST_FULL : ST_EMPTY;
  assign w_free      = (w_state == ST_EMPTY) || out_ready_i;
  assign in_ready_o  = w_free;
  assign w_accept    = in_valid_i && w_free;
  assign w_consume   = (w_state == ST_FULL) && out_ready_i;
  assign w_lane_done = w_accept && ((w_cnt == CW'(RATIO - 1)) || in_last_i);

`ifdef AXIS_WORD_PACKER_FLUSH_EN
  // A flush drains whatever is buffered, including a lane accepted in the same cycle
  assign w_flush = flush_i && w_free && ((w_cnt != '0) || w_accept);
`else
  assign w_flush = 1'b0;
`endif

  assign w_complete = w_lane_done || w_flush;
  assign w_fill     = CNT_W'(w_cnt) + CNT_W'(w_accept);

  axis_word_packer_acc #(
    .IN_W (IN_W),
    .RATIO(RATIO),
    .CW   (CW)
  ) u_acc (
    .i_clk     (clk_i),
    .i_cke     (cke_i),
    .i_rst     (rst_i),
    .i_lane_vld(w_accept),
    .i_lane_dat(in_data_i),
    .i_clr     (w_complete),
    .o_cnt     (w_cnt),
    .o_merged  (w_merged)
  );

  iob_reg_re #(.DATA_W(AXI_DATA_W)) u_data_reg (
    .clk_i (clk_i),
    .cke_i (cke_i),
    .rst_i (rst_i),
    .en_i  (w_complete),
    .data_i(w_merged),
    .data_o(out_data_o)
  );

  iob_reg_re #(.DATA_W(1)) u_last_reg (
    .clk_i (clk_i),
    .cke_i (cke_i),
    .rst_i (rst_i),
    .en_i  (w_complete),
    .data_i(w_accept && in_last_i),
    .data_o(out_last_o)
  );

  iob_reg_re #(.DATA_W(CNT_W)) u_nbytes_reg (
    .clk_i (clk_i),
    .cke_i (cke_i),
    .rst_i (rst_i),
    .en_i  (w_complete),
    .data_i(w_fill),
    .data_o(out_nbytes_o)
  );

  // Valid reloads on completion, drops on a consume without a new word
  iob_reg_re #(.DATA_W(1)) u_valid_reg (
    .clk_i (clk_i),
    .cke_i (cke_i),
    .rst_i (rst_i),
    .en_i  (w_complete || w_consume),
    .data_i(w_complete),
    .data_o(out_valid_o)
  );

endmodule

// File: tb/tb_axis_word_packer.sv
// Self-checking bench for axis_word_packer: directed frames plus randomized traffic against a queue-based model.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the falling edge.
// The model packs accepted lanes from a queue and tracks the single held output word.
`timescale 1ns/1ps
module tb_axis_word_packer;

  localparam int IN_W       = 8;
  localparam int AXI_DATA_W = 32;
  localparam int RATIO      = AXI_DATA_W / IN_W;
  localparam int CNT_W      = $clog2(RATIO) + 1;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] d;
    logic                  l;
    logic [CNT_W-1:0]      nb;
  } word_t;

  logic                  clk_i = 1'b0;
  logic                  cke_i = 1'b1;
  logic                  rst_i = 1'b1;
  logic [IN_W-1:0]       in_data_i = '0;
  logic                  in_valid_i = 1'b0;
  logic                  in_last_i = 1'b0;
  logic                  in_ready_o;
  logic [AXI_DATA_W-1:0] out_data_o;
  logic                  out_valid_o;
  logic                  out_last_o;
  logic [CNT_W-1:0]      out_nbytes_o;
  logic                  out_ready_i = 1'b1;
`ifdef AXIS_WORD_PACKER_FLUSH_EN
  logic                  flush_i = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [IN_W-1:0]       cur[$];
  logic                  m_vld = 1'b0;
  logic [AXI_DATA_W-1:0] m_dat = '0;
  logic                  m_last = 1'b0;
  int                    m_nb = 0;

  // Observation records filled by cycle()
  word_t got[$];
  int    acc_cnt = 0;
  int    rdy_low = 0;

  always #5 clk_i = ~clk_i;

  axis_word_packer #(
    .IN_W      (IN_W),
    .AXI_DATA_W(AXI_DATA_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .cke_i       (cke_i),
    .rst_i       (rst_i),
`ifdef AXIS_WORD_PACKER_FLUSH_EN
    .flush_i     (flush_i),
`endif
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_last_i   (in_last_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_last_o  (out_last_o),
    .out_nbytes_o(out_nbytes_o),
    .out_ready_i (out_ready_i)
  );

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_tick();
    logic free, acc, done, fl;
    fl = 1'b0;
`ifdef AXIS_WORD_PACKER_FLUSH_EN
    fl = flush_i;
`endif
    if (!cke_i) return;
    if (rst_i) begin
      m_vld = 1'b0; m_dat = '0; m_last = 1'b0; m_nb = 0; cur.delete();
      return;
    end
    free = !m_vld || out_ready_i;
    acc  = in_valid_i && free;
    if (m_vld && out_ready_i) m_vld = 1'b0;
    if (acc) cur.push_back(in_data_i);
    done = acc && (in_last_i || cur.size() == RATIO);
    if (fl && free && cur.size() > 0) done = 1'b1;
    if (done) begin
      m_dat = '0;
      foreach (cur[i]) m_dat = m_dat | (AXI_DATA_W'(cur[i]) << (IN_W * i));
      m_last = acc && in_last_i;
      m_nb   = cur.size();
      m_vld  = 1'b1;
      cur.delete();
    end
  endtask

  // Called between a falling edge and the next rising edge
  task automatic tick();
    model_tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one cycle and record accepted lanes / consumed words (no checking here)
  task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic l, input logic r);
    in_valid_i = v; in_data_i = d; in_last_i = l; out_ready_i = r;
    @(negedge clk_i);
    if (v && in_ready_o && cke_i) acc_cnt++;
    if (!in_ready_o) rdy_low++;
    if (out_valid_o && out_ready_i && cke_i) got.push_back('{out_data_o, out_last_o, out_nbytes_o});
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cke_i = 1'b1; in_valid_i = 1'b0; in_last_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1;
    repeat (2) begin @(negedge clk_i); tick(); end
    @(negedge clk_i);
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid_o); end
    checks++; if (out_data_o !== '0) begin errors++; $display("FAIL reset_data got %h want 0", out_data_o); end
    checks++; if (out_last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last_o); end
    checks++; if (out_nbytes_o !== '0) begin errors++; $display("FAIL reset_nbytes got %0d want 0", out_nbytes_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready_o); end
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_full_frame();
    got.delete(); rdy_low = 0;
    for (int i = 1; i <= 8; i++) cycle(1'b1, IN_W'(i), i == 8, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (rdy_low != 0) begin errors++; $display("FAIL full_ready_low got %0d want 0", rdy_low); end
    checks++; if (got.size() != 2) begin errors++; $display("FAIL full_count got %0d want 2", got.size()); end
    if (got.size() == 2) begin
      checks++; if (got[0] !== word_t'({32'h04030201, 1'b0, 3'd4})) begin errors++; $display("FAIL full_w0 got %h/%b/%0d want 04030201/0/4", got[0].d, got[0].l, got[0].nb); end
      checks++; if (got[1] !== word_t'({32'h08070605, 1'b1, 3'd4})) begin errors++; $display("FAIL full_w1 got %h/%b/%0d want 08070605/1/4", got[1].d, got[1].l, got[1].nb); end
    end
  endtask

  task automatic test_partial();
    got.delete();
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    cycle(1'b1, 8'hBB, 1'b0, 1'b1);
    cycle(1'b1, 8'hCC, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL partial_count got %0d want 1", got.size()); end
    if (got.size() == 1) begin
      checks++; if (got[0] !== word_t'({32'h00CCBBAA, 1'b1, 3'd3})) begin errors++; $display("FAIL partial_w got %h/%b/%0d want 00ccbbaa/1/3", got[0].d, got[0].l, got[0].nb); end
    end
  endtask

  task automatic test_single();
    in_valid_i = 1'b1; in_data_i = 8'h5A; in_last_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk_i);
    checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin errors++; $display("FAIL single_accept got rdy=%b vld=%b want rdy=1 vld=0", in_ready_o, out_valid_o); end
    tick();
    in_valid_i = 1'b0; in_last_i = 1'b0;
    @(negedge clk_i);
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL single_latency got vld=%b want 1", out_valid_o); end
    checks++; if (out_data_o !== 32'h0000005A || out_nbytes_o !== 3'd1 || out_last_o !== 1'b1) begin errors++; $display("FAIL single_word got %h/%b/%0d want 0000005a/1/1", out_data_o, out_last_o, out_nbytes_o); end
    tick();
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    got.delete(); acc_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, IN_W'(8'h31 + acc_cnt), acc_cnt == 11, 1'b0);
      if (acc_cnt == 4 && c >= 4) begin
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 32'h34333231) begin errors++; $display("FAIL bp_hold got %b/%h want 1/34333231", out_valid_o, out_data_o); end
      end
    end
    checks++; if (acc_cnt != 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", acc_cnt); end
    for (int c = 0; c < 40 && !(got.size() == 3 && acc_cnt == 12); c++)
      cycle(acc_cnt < 12, IN_W'(8'h31 + acc_cnt), acc_cnt == 11, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got.size()); end
    if (got.size() == 3) begin
      checks++; if (got[0] !== word_t'({32'h34333231, 1'b0, 3'd4})) begin errors++; $display("FAIL bp_w0 got %h/%b/%0d want 34333231/0/4", got[0].d, got[0].l, got[0].nb); end
      checks++; if (got[1] !== word_t'({32'h38373635, 1'b0, 3'd4})) begin errors++; $display("FAIL bp_w1 got %h/%b/%0d want 38373635/0/4", got[1].d, got[1].l, got[1].nb); end
      checks++; if (got[2] !== word_t'({32'h3C3B3A39, 1'b1, 3'd4})) begin errors++; $display("FAIL bp_w2 got %h/%b/%0d want 3c3b3a39/1/4", got[2].d, got[2].l, got[2].nb); end
    end
  endtask

  task automatic test_reset_midframe();
    got.delete();
    cycle(1'b1, 8'hE1, 1'b0, 1'b1);
    cycle(1'b1, 8'hE2, 1'b0, 1'b1);
    rst_i = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b1);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1, IN_W'(8'h11 + i), i == 3, 1'b1);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL midrst_count got %0d want 1", got.size()); end
    if (got.size() == 1) begin
      checks++; if (got[0] !== word_t'({32'h14131211, 1'b1, 3'd4})) begin errors++; $display("FAIL midrst_w got %h/%b/%0d want 14131211/1/4", got[0].d, got[0].l, got[0].nb); end
    end
  endtask

`ifdef AXIS_WORD_PACKER_FLUSH_EN
  task automatic test_flush();
    got.delete();
    cycle(1'b1, 8'h10, 1'b0, 1'b1);
    cycle(1'b1, 8'h20, 1'b0, 1'b1);
    flush_i = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b1);
    flush_i = 1'b0;
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL flush_count got %0d want 1", got.size()); end
    if (got.size() == 1) begin
      checks++; if (got[0] !== word_t'({32'h00002010, 1'b0, 3'd2})) begin errors++; $display("FAIL flush_w got %h/%b/%0d want 00002010/0/2", got[0].d, got[0].l, got[0].nb); end
    end
    flush_i = 1'b1;
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    flush_i = 1'b0;
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL flush_empty got %0d words want 1", got.size()); end
  endtask
`endif

  task automatic test_random();
    logic exp_rdy;
    for (int c = 0; c < 600; c++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      in_data_i   = IN_W'($urandom);
      in_last_i   = ($urandom_range(0, 5) == 0);
      out_ready_i = ($urandom_range(0, 9) < 7);
      cke_i       = ($urandom_range(0, 9) != 0);
      rst_i       = ($urandom_range(0, 79) == 0);
`ifdef AXIS_WORD_PACKER_FLUSH_EN
      flush_i     = ($urandom_range(0, 15) == 0);
`endif
      @(negedge clk_i);
      exp_rdy = !m_vld || out_ready_i;
      checks++; if (in_ready_o !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, in_ready_o, exp_rdy); end
      checks++; if (out_valid_o !== m_vld) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, out_valid_o, m_vld); end
      if (m_vld) begin
        checks++; if (out_data_o !== m_dat) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", c, out_data_o, m_dat); end
        checks++; if (out_last_o !== m_last) begin errors++; $display("FAIL rnd_last cyc %0d got %b want %b", c, out_last_o, m_last); end
        checks++; if (out_nbytes_o !== CNT_W'(m_nb)) begin errors++; $display("FAIL rnd_nbytes cyc %0d got %0d want %0d", c, out_nbytes_o, m_nb); end
      end
      tick();
    end
    cke_i = 1'b1; rst_i = 1'b0;
`ifdef AXIS_WORD_PACKER_FLUSH_EN
    flush_i = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_partial();
    test_single();
    test_backpressure();
    test_reset_midframe();
`ifdef AXIS_WORD_PACKER_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
